// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: frame controller between the UART RX/TX datapath and the ALU.
// Assembles a three-byte command (operand A, operand B, opcode), presents it
// to the ALU, captures the single-byte result and drives the TX handshake.
// A partial frame is discarded if the next byte does not arrive in time.
module uart_alu_ctrl #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic               o_busy,
    output logic               o_timeout
);

    localparam int NB_CNT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    state_t             state_q, state_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic [NB_DATA-1:0] dataA_q, dataA_d;
    logic [NB_DATA-1:0] dataB_q, dataB_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_DATA-1:0] txData_q, txData_d;
    logic               timeoutPulse;

    // State, inter-byte counter and the operand/result holding registers.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dataA_q  <= '0;
            dataB_q  <= '0;
            op_q     <= '0;
            txData_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dataA_q  <= dataA_d;
            dataB_q  <= dataB_d;
            op_q     <= op_d;
            txData_q <= txData_d;
        end
    end

    // Frame sequencing: a byte arriving on the terminal count is accepted,
    // and bytes arriving while busy are simply dropped.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dataA_d      = dataA_q;
        dataB_d      = dataB_q;
        op_d         = op_q;
        txData_d     = txData_q;
        timeoutPulse = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_rx_done) begin
                    dataA_d = i_rx_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    dataB_d = i_rx_data;
                    cnt_d   = '0;
                    state_d = WAIT_OP;
                end else if (cnt_q == CNT_LAST) begin
                    timeoutPulse = 1'b1;
                    cnt_d        = '0;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + NB_CNT'(1);
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    op_d    = i_rx_data[NB_OP-1:0];
                    cnt_d   = '0;
                    state_d = EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    timeoutPulse = 1'b1;
                    cnt_d        = '0;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + NB_CNT'(1);
                end
            end
            EXEC: begin
                txData_d = i_alu_result;
                state_d  = SEND;
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        o_tx_start = (state_q == SEND);
        o_busy     = (state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_TX);
        o_timeout  = timeoutPulse;
        o_tx_data  = txData_q;
        o_data_a   = dataA_q;
        o_data_b   = dataB_q;
        o_op       = op_q;
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb_uart_alu_ctrl: table vectors, hand-written corner sequences and a random
// byte stream checked against a frame-level reference model.
module tb_uart_alu_ctrl;

   localparam int TB_TIMEOUT = 16;

   logic       clk;
   logic       i_rst;
   logic       i_rx_done;
   logic [7:0] i_rx_data;
   logic       i_tx_done;
   logic [7:0] i_alu_result;
   logic       o_tx_start;
   logic [7:0] o_tx_data;
   logic [7:0] o_data_a;
   logic [7:0] o_data_b;
   logic [5:0] o_op;
   logic       o_busy;
   logic       o_timeout;

   int errors = 0;
   int checks = 0;
   int timeoutSeen = 0;
   int txStartSeen = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] opByte;
      logic [5:0] expOp;
      logic [7:0] expRes;
   } vec_t;

   vec_t vecs[10];

   uart_alu_ctrl #(
      .NB_DATA(8),
      .NB_OP(6),
      .TIMEOUT_CYCLES(TB_TIMEOUT)
   ) dut (
      .clk(clk),
      .i_rst(i_rst),
      .i_rx_done(i_rx_done),
      .i_rx_data(i_rx_data),
      .i_tx_done(i_tx_done),
      .i_alu_result(i_alu_result),
      .o_tx_start(o_tx_start),
      .o_tx_data(o_tx_data),
      .o_data_a(o_data_a),
      .o_data_b(o_data_b),
      .o_op(o_op),
      .o_busy(o_busy),
      .o_timeout(o_timeout)
   );

   // Behavioural ALU used both as the DUT's companion and as the reference.
   function automatic logic [7:0] aluModel(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      case (op)
         6'h20: return a + b;
         6'h22: return a - b;
         6'h24: return a & b;
         6'h25: return a | b;
         6'h26: return a ^ b;
         6'h27: return ~(a | b);
         6'h03: return 8'($signed(a) >>> b);
         6'h02: return a >> b;
         default: return 8'h00;
      endcase
   endfunction

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational ALU sitting on the controller's operand outputs.
   always_comb i_alu_result = aluModel(o_data_a, o_data_b, o_op);

   // Pulse monitors, sampled mid-cycle while inputs and state are stable.
   always @(negedge clk) begin
      if (o_timeout) timeoutSeen = timeoutSeen + 1;
      if (o_tx_start) txStartSeen = txStartSeen + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      i_rx_done = 1'b1;
      i_rx_data = b;
      tick();
      i_rx_done = 1'b0;
      i_rx_data = 8'h00;
   endtask

   task automatic pulseTxDone();
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
   endtask

   task automatic pulseReset();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " data_a"}, o_data_a, 0);
      checkOutput({tag, " data_b"}, o_data_b, 0);
      checkOutput({tag, " op"}, o_op, 0);
      checkOutput({tag, " tx_data"}, o_tx_data, 0);
      checkOutput({tag, " tx_start"}, o_tx_start, 0);
      checkOutput({tag, " busy"}, o_busy, 0);
      checkOutput({tag, " timeout"}, o_timeout, 0);
   endtask

   // Called in the EXEC cycle; walks SEND and WAIT_TX back to IDLE.
   task automatic finishFrame(input logic [7:0] expRes, input int txWait);
      int base;
      base = txStartSeen;
      checkOutput("exec no start", o_tx_start, 0);
      checkOutput("exec busy", o_busy, 1);
      tick();
      checkOutput("start latency", o_tx_start, 1);
      checkOutput("tx_data", o_tx_data, expRes);
      tick();
      idleCycles(txWait);
      checkOutput("tx_start single", o_tx_start, 0);
      checkOutput("tx_data held", o_tx_data, expRes);
      checkOutput("wait_tx busy", o_busy, 1);
      pulseTxDone();
      checkOutput("idle after tx", o_busy, 0);
      checkOutput("one start per frame", txStartSeen - base, 1);
   endtask

   task automatic runFrame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opByte,
                           input logic [5:0] expOp, input logic [7:0] expRes);
      applyStimulus(a);
      applyStimulus(b);
      applyStimulus(opByte);
      checkOutput("data_a", o_data_a, a);
      checkOutput("data_b", o_data_b, b);
      checkOutput("op", o_op, expOp);
      finishFrame(expRes, 3);
   endtask

   initial begin
      int base;
      int hits;
      int firstAt;
      int expTimeouts;
      int frames;
      int nbuf;
      int g;
      int gaps[9];
      logic [7:0] fa;
      logic [7:0] fb;
      logic [7:0] rb;

      vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
      vecs[1] = '{8'h0A, 8'h04, 8'hE2, 6'h22, 8'h06};
      vecs[2] = '{8'hF0, 8'h3C, 8'h24, 6'h24, 8'h30};
      vecs[3] = '{8'hF0, 8'h0F, 8'h65, 6'h25, 8'hFF};
      vecs[4] = '{8'hAA, 8'hFF, 8'hA6, 6'h26, 8'h55};
      vecs[5] = '{8'hFF, 8'h01, 8'h20, 6'h20, 8'h00};
      vecs[6] = '{8'h00, 8'h01, 8'h22, 6'h22, 8'hFF};
      vecs[7] = '{8'h81, 8'h02, 8'h03, 6'h03, 8'hE0};
      vecs[8] = '{8'h81, 8'h02, 8'hC2, 6'h02, 8'h20};
      vecs[9] = '{8'h12, 8'h34, 8'h27, 6'h27, 8'hC9};
      gaps = '{0, 1, 2, 3, 14, 15, 16, 17, 20};

      i_rst = 1'b1;
      i_rx_done = 1'b0;
      i_rx_data = 8'h00;
      i_tx_done = 1'b0;
      idleCycles(3);
      checkAllZero("reset");
      i_rst = 1'b0;

      $display("[TB] table vectors");
      foreach (vecs[i]) runFrame(vecs[i].a, vecs[i].b, vecs[i].opByte, vecs[i].expOp, vecs[i].expRes);

      $display("[TB] timeout in WAIT_B");
      applyStimulus(8'h11);
      base = timeoutSeen;
      hits = 0;
      firstAt = -1;
      for (int i = 0; i < 20; i++) begin
         if (o_timeout) begin
            hits++;
            if (firstAt < 0) firstAt = i;
         end
         tick();
      end
      checkOutput("timeout pulses", hits, 1);
      checkOutput("timeout cycle", firstAt, TB_TIMEOUT - 1);
      checkOutput("timeout monitor", timeoutSeen - base, 1);
      checkOutput("timeout keeps a", o_data_a, 8'h11);
      checkOutput("timeout idle", o_busy, 0);
      runFrame(8'h01, 8'h02, 8'h20, 6'h20, 8'h03);

      $display("[TB] timeout in WAIT_OP");
      applyStimulus(8'h44);
      applyStimulus(8'h55);
      base = timeoutSeen;
      idleCycles(TB_TIMEOUT + 2);
      checkOutput("op timeout monitor", timeoutSeen - base, 1);
      checkOutput("op timeout keeps b", o_data_b, 8'h55);
      runFrame(8'h09, 8'h01, 8'h22, 6'h22, 8'h08);

      $display("[TB] byte on terminal count");
      applyStimulus(8'h07);
      applyStimulus(8'h09);
      base = timeoutSeen;
      idleCycles(TB_TIMEOUT - 1);
      i_rx_done = 1'b1;
      i_rx_data = 8'h20;
      #1;
      checkOutput("boundary no timeout now", o_timeout, 0);
      tick();
      i_rx_done = 1'b0;
      checkOutput("boundary no timeout", timeoutSeen - base, 0);
      checkOutput("boundary op", o_op, 6'h20);
      finishFrame(8'h10, 1);

      $display("[TB] busy drop");
      applyStimulus(8'h0A);
      applyStimulus(8'h04);
      applyStimulus(8'hE2);
      checkOutput("mask op", o_op, 6'h22);
      tick();
      checkOutput("mask tx_data", o_tx_data, 8'h06);
      tick();
      applyStimulus(8'h7F);
      checkOutput("drop still busy", o_busy, 1);
      checkOutput("drop keeps a", o_data_a, 8'h0A);
      i_rx_done = 1'b1;
      i_rx_data = 8'h7F;
      pulseTxDone();
      i_rx_done = 1'b0;
      checkOutput("drop idle", o_busy, 0);
      checkOutput("drop coincident a", o_data_a, 8'h0A);
      idleCycles(2);
      base = txStartSeen;
      runFrame(8'h02, 8'h02, 8'h20, 6'h20, 8'h04);
      checkOutput("drop single start", txStartSeen - base, 1);

      $display("[TB] reset in WAIT_OP");
      applyStimulus(8'h33);
      applyStimulus(8'h44);
      pulseReset();
      checkAllZero("rst wait_op");
      base = txStartSeen;
      pulseTxDone();
      idleCycles(3);
      checkOutput("rst stray tx_done", txStartSeen - base, 0);
      runFrame(8'h06, 8'h07, 8'h20, 6'h20, 8'h0D);

      $display("[TB] reset in WAIT_TX");
      applyStimulus(8'h10);
      applyStimulus(8'h20);
      applyStimulus(8'h20);
      idleCycles(3);
      checkOutput("pre-reset tx_data", o_tx_data, 8'h30);
      pulseReset();
      checkAllZero("rst wait_tx");
      base = txStartSeen;
      pulseTxDone();
      idleCycles(3);
      checkOutput("rst tx stray", txStartSeen - base, 0);
      runFrame(8'h21, 8'h01, 8'h22, 6'h22, 8'h20);

      $display("[TB] random stream");
      expTimeouts = 0;
      frames = 0;
      nbuf = 0;
      fa = 8'h00;
      fb = 8'h00;
      base = timeoutSeen;
      hits = txStartSeen;
      for (int n = 0; n < 90; n++) begin
         g = gaps[$urandom_range(0, 8)];
         idleCycles(g);
         if (nbuf > 0 && g >= TB_TIMEOUT) begin
            nbuf = 0;
            expTimeouts++;
         end
         rb = 8'($urandom);
         applyStimulus(rb);
         if (nbuf == 0) fa = rb;
         else if (nbuf == 1) fb = rb;
         nbuf++;
         if (nbuf == 3) begin
            checkOutput("rnd data_a", o_data_a, fa);
            checkOutput("rnd data_b", o_data_b, fb);
            checkOutput("rnd op", o_op, rb[5:0]);
            finishFrame(aluModel(fa, fb, rb[5:0]), $urandom_range(0, 4));
            frames++;
            nbuf = 0;
         end
      end
      checkOutput("rnd timeouts", timeoutSeen - base, expTimeouts);
      checkOutput("rnd starts", txStartSeen - hits, frames);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
